// File: rtl/readout_capture_ctrl.sv
// Frame/line capture sequencer: windows one armed frame from the deserializer onto a
// valid/ready stream with SOF/EOL markers. Optional macro READOUT_TEST_PATTERN_EN adds test_mode.
module readout_capture_ctrl #(
  parameter int PIX_W = 16,
  parameter int CNT_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               abort,
  input  logic               frame_start,
  input  logic               hblank,
  input  logic [2*PIX_W-1:0] din,
  input  logic               din_valid,
  input  logic [CNT_W-1:0]   cfg_h_skip,
  input  logic [CNT_W-1:0]   cfg_h_active,
  input  logic [CNT_W-1:0]   cfg_v_skip,
  input  logic [CNT_W-1:0]   cfg_v_active,
`ifdef READOUT_TEST_PATTERN_EN
  input  logic               test_mode,
`endif
  output logic [2*PIX_W-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_sof,
  output logic               m_eol,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               sync_err
);

  typedef enum logic [2:0] {
    IDLE, WAIT_FRAME, V_SKIP, LINE, DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] h_skip_reg, h_active_reg, v_skip_reg, v_active_reg;
  logic [CNT_W-1:0] vcnt_reg, lcnt_reg, hcnt_reg, fwd_cnt_reg;
  logic             hb_d_reg;
  logic             sof_pending_reg;

  logic             line_end, pix_in, in_window, fwd, restart, arm_ok, can_load;
  logic [CNT_W-1:0] h_lim;
  logic [2*PIX_W-1:0] fwd_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign line_end  = hblank & ~hb_d_reg;
  assign h_lim     = h_skip_reg + h_active_reg;
  assign arm_ok    = (state_reg == IDLE) & arm & ~abort;
  assign restart   = frame_start & ~abort & ((state_reg == V_SKIP) | (state_reg == LINE));
  assign pix_in    = (state_reg == LINE) & din_valid & ~hblank;
  assign in_window = (hcnt_reg >= h_skip_reg) & (hcnt_reg < h_lim);
  // A word coinciding with abort or a frame restart belongs to no valid line.
  assign fwd       = pix_in & in_window & ~abort & ~frame_start;
  assign can_load  = ~m_valid | m_ready;

`ifdef READOUT_TEST_PATTERN_EN
  assign fwd_data = test_mode ? {PIX_W'(lcnt_reg), PIX_W'(fwd_cnt_reg)} : din;
`else
  assign fwd_data = din;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (arm) begin
          state_next = ((cfg_h_active == '0) || (cfg_v_active == '0)) ? DONE : WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          state_next = (v_skip_reg == '0) ? LINE : V_SKIP;
        end
      end
      V_SKIP: begin
        if (restart) begin
          state_next = V_SKIP;
        end else if (v_skip_reg == '0) begin
          state_next = LINE;
        end else if (line_end && (sat_inc(vcnt_reg) == v_skip_reg)) begin
          state_next = LINE;
        end
      end
      LINE: begin
        if (restart) begin
          state_next = V_SKIP;
        end else if (line_end && (sat_inc(lcnt_reg) == v_active_reg)) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
    end
  end

  // busy falls in the same cycle that done pulses.
  assign busy = (state_reg != IDLE) & (state_reg != DONE);
  assign done = (state_reg == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_skip_reg      <= '0;
      h_active_reg    <= '0;
      v_skip_reg      <= '0;
      v_active_reg    <= '0;
      vcnt_reg        <= '0;
      lcnt_reg        <= '0;
      hcnt_reg        <= '0;
      fwd_cnt_reg     <= '0;
      hb_d_reg        <= 1'b0;
      sof_pending_reg <= 1'b0;
      overflow        <= 1'b0;
      sync_err        <= 1'b0;
    end else begin
      hb_d_reg <= hblank;
      if (abort) begin
        vcnt_reg    <= '0;
        lcnt_reg    <= '0;
        hcnt_reg    <= '0;
        fwd_cnt_reg <= '0;
      end else if (arm_ok) begin
        h_skip_reg      <= cfg_h_skip;
        h_active_reg    <= cfg_h_active;
        v_skip_reg      <= cfg_v_skip;
        v_active_reg    <= cfg_v_active;
        vcnt_reg        <= '0;
        lcnt_reg        <= '0;
        hcnt_reg        <= '0;
        fwd_cnt_reg     <= '0;
        sof_pending_reg <= 1'b1;
        overflow        <= 1'b0;
        sync_err        <= 1'b0;
      end else if (restart) begin
        vcnt_reg        <= '0;
        lcnt_reg        <= '0;
        hcnt_reg        <= '0;
        fwd_cnt_reg     <= '0;
        sof_pending_reg <= 1'b1;
        sync_err        <= 1'b1;
      end else begin
        if ((state_reg == V_SKIP) && line_end) begin
          vcnt_reg <= sat_inc(vcnt_reg);
        end
        if (state_reg == LINE) begin
          if (line_end) begin
            hcnt_reg    <= '0;
            fwd_cnt_reg <= '0;
            lcnt_reg    <= sat_inc(lcnt_reg);
            if (fwd_cnt_reg < h_active_reg) begin
              sync_err <= 1'b1;
            end
          end else if (pix_in) begin
            hcnt_reg <= sat_inc(hcnt_reg);
            if (fwd) begin
              fwd_cnt_reg <= sat_inc(fwd_cnt_reg);
            end
          end
        end
        if (fwd) begin
          sof_pending_reg <= 1'b0;
          if (!can_load) begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

  // Output register: loads only when empty or draining this cycle, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_sof   <= 1'b0;
      m_eol   <= 1'b0;
    end else if (abort) begin
      m_valid <= 1'b0;
    end else if (fwd && can_load) begin
      m_data  <= fwd_data;
      m_valid <= 1'b1;
      m_sof   <= sof_pending_reg;
      m_eol   <= (sat_inc(fwd_cnt_reg) == h_active_reg);
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_readout_capture_ctrl.sv
// Directed bench for readout_capture_ctrl: linear stimulus, hand-computed expectations,
// immediate assertions at each comparison point.
module tb_readout_capture_ctrl;
  localparam int PIX_W = 16;
  localparam int CNT_W = 12;

  logic clk = 1'b0;
  logic reset, arm, abort, frame_start, hblank, din_valid, m_ready;
  logic [2*PIX_W-1:0] din;
  logic [CNT_W-1:0] cfg_h_skip, cfg_h_active, cfg_v_skip, cfg_v_active;
  logic [2*PIX_W-1:0] m_data;
  logic m_valid, m_sof, m_eol, busy, done, overflow, sync_err;
`ifdef READOUT_TEST_PATTERN_EN
  logic test_mode;
`endif

  readout_capture_ctrl #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort), .frame_start(frame_start),
    .hblank(hblank), .din(din), .din_valid(din_valid),
    .cfg_h_skip(cfg_h_skip), .cfg_h_active(cfg_h_active),
    .cfg_v_skip(cfg_v_skip), .cfg_v_active(cfg_v_active),
`ifdef READOUT_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_sof(m_sof), .m_eol(m_eol),
    .busy(busy), .done(done), .overflow(overflow), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Sink-side monitor, sampled on the falling edge.
  int acc_n = 0, sof_cnt = 0, eol_cnt = 0, done_cnt = 0, valid_cyc = 0;
  logic [2*PIX_W-1:0] acc_data [0:63];
  logic [63:0] eol_bits = '0;
  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      acc_data[acc_n % 64] <= m_data;
      eol_bits[acc_n % 64] <= m_eol;
      acc_n   <= acc_n + 1;
      sof_cnt <= sof_cnt + (m_sof ? 1 : 0);
      eol_cnt <= eol_cnt + (m_eol ? 1 : 0);
    end
    if (done)    done_cnt  <= done_cnt + 1;
    if (m_valid) valid_cyc <= valid_cyc + 1;
  end

  int checks = 0, passes = 0, fails = 0;
  int a0, s0, e0, d0, v0, amid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int hs, input int ha, input int vs, input int va);
    cfg_h_skip = CNT_W'(hs); cfg_h_active = CNT_W'(ha);
    cfg_v_skip = CNT_W'(vs); cfg_v_active = CNT_W'(va);
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(1); arm = 1'b0; tick(1);
  endtask

  task automatic do_fs();
    frame_start = 1'b1; tick(1); frame_start = 1'b0; tick(2);
  endtask

  // nw words on consecutive cycles, din = {line, word index}, then blank cycles.
  task automatic line(input int ln, input int nw, input int blank);
    for (int i = 0; i < nw; i++) begin
      hblank = 1'b0; din_valid = 1'b1; din = {16'(ln), 16'(i)};
      tick(1);
    end
    hblank = 1'b1; din_valid = 1'b0;
    if (blank > 0) tick(blank);
  endtask

  task automatic snap();
    a0 = acc_n; s0 = sof_cnt; e0 = eol_cnt; d0 = done_cnt; v0 = valid_cyc;
  endtask

  initial begin
    reset = 1'b1; arm = 0; abort = 0; frame_start = 0; hblank = 1; din_valid = 0;
    din = '0; m_ready = 1'b1; set_cfg(0, 0, 0, 0);
`ifdef READOUT_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_flags", 64'({busy, done, overflow, sync_err, m_sof, m_eol}), 64'd0);

    // 1: normal frame, sink always ready
    tick(1); snap();
    set_cfg(2, 4, 1, 2); do_arm();
    @(negedge clk); check("t1_busy_armed", 64'(busy), 64'd1);
    tick(1); do_fs();
    line(0, 8, 4); line(1, 8, 4); line(2, 8, 0);
    @(negedge clk); check("t1_done_not_early", 64'(done), 64'd0);
    @(negedge clk); check("t1_done_pulse", 64'(done), 64'd1);
    check("t1_busy_drop", 64'(busy), 64'd0);
    @(negedge clk); check("t1_done_one_cycle", 64'(done), 64'd0);
    tick(3);
    check("t1_words", 64'(acc_n - a0), 64'd8);
    check("t1_sof", 64'(sof_cnt - s0), 64'd1);
    check("t1_eol_cnt", 64'(eol_cnt - e0), 64'd2);
    check("t1_eol_w4", 64'(eol_bits[(a0 + 3) % 64]), 64'd1);
    check("t1_eol_w8", 64'(eol_bits[(a0 + 7) % 64]), 64'd1);
    check("t1_word1", 64'(acc_data[a0 % 64]), 64'h0001_0002);
    check("t1_word4", 64'(acc_data[(a0 + 3) % 64]), 64'h0001_0005);
    check("t1_word5", 64'(acc_data[(a0 + 4) % 64]), 64'h0002_0002);
    check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t1_overflow", 64'(overflow), 64'd0);
    check("t1_sync_err", 64'(sync_err), 64'd0);

    // 2: sink stalled, only the first word survives
    snap(); m_ready = 1'b0;
    do_arm(); do_fs();
    line(0, 8, 4); line(1, 8, 4); line(2, 8, 4);
    @(negedge clk);
    check("t2_m_valid_held", 64'(m_valid), 64'd1);
    check("t2_m_data_held", 64'(m_data), 64'h0001_0002);
    check("t2_m_sof_held", 64'(m_sof), 64'd1);
    check("t2_m_eol_held", 64'(m_eol), 64'd0);
    check("t2_overflow", 64'(overflow), 64'd1);
    check("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
    tick(1); m_ready = 1'b1; tick(3);
    check("t2_drained", 64'(acc_n - a0), 64'd1);
    check("t2_m_valid_clr", 64'(m_valid), 64'd0);

    // 3: short second captured line
    snap();
    do_arm();
    @(negedge clk); check("t3_arm_clr_ovf", 64'(overflow), 64'd0);
    tick(1); do_fs();
    line(0, 8, 4); line(1, 8, 4); line(2, 5, 4);
    check("t3_words", 64'(acc_n - a0), 64'd7);
    check("t3_sync_err", 64'(sync_err), 64'd1);
    check("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("t3_eol_cnt", 64'(eol_cnt - e0), 64'd1);

    // 4: frame_start mid-capture restarts the frame
    snap();
    do_arm();
    @(negedge clk); check("t4_arm_clr_sync", 64'(sync_err), 64'd0);
    tick(1); do_fs();
    line(0, 8, 4); line(1, 8, 4);
    amid = acc_n;
    check("t4_pre_words", 64'(amid - a0), 64'd4);
    do_fs();
    @(negedge clk);
    check("t4_sync_err", 64'(sync_err), 64'd1);
    check("t4_busy", 64'(busy), 64'd1);
    tick(1);
    line(2, 8, 4); line(3, 8, 4); line(4, 8, 4);
    check("t4_post_words", 64'(acc_n - amid), 64'd8);
    check("t4_post_word1", 64'(acc_data[amid % 64]), 64'h0003_0002);
    check("t4_done_cnt", 64'(done_cnt - d0), 64'd1);

    // 5a: zero active lines completes immediately with no data
    snap(); set_cfg(2, 4, 1, 0);
    arm = 1'b1;
    @(negedge clk); check("t5_done_before", 64'(done), 64'd0);
    tick(1); arm = 1'b0;
    @(negedge clk); check("t5_done_pulse", 64'(done), 64'd1);
    tick(1);
    @(negedge clk); check("t5_done_end", 64'(done), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_no_valid", 64'(valid_cyc - v0), 64'd0);

    // 5b: abort with a word pending in the output register
    tick(1); set_cfg(2, 4, 1, 2); snap();
    do_arm(); do_fs();
    line(0, 8, 4);
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hblank = 1'b0; din_valid = 1'b1; din = {16'd1, 16'(i)};
      tick(1);
    end
    din_valid = 1'b0; tick(1);
    @(negedge clk);
    check("t5_pending", 64'(m_valid), 64'd1);
    tick(1); abort = 1'b1; tick(1); abort = 1'b0;
    @(negedge clk);
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_valid", 64'(m_valid), 64'd0);
    hblank = 1'b1; tick(5);
    check("t5_abort_no_done", 64'(done_cnt - d0), 64'd0);
    m_ready = 1'b1;

`ifdef READOUT_TEST_PATTERN_EN
    // 6: test pattern replaces pixel data
    tick(2); snap(); test_mode = 1'b1;
    do_arm(); do_fs();
    line(0, 8, 4); line(1, 8, 4); line(2, 8, 4);
    check("t6_words", 64'(acc_n - a0), 64'd8);
    for (int k = 0; k < 4; k++) begin
      check("t6_line0", 64'(acc_data[(a0 + k) % 64]), 64'(k));
    end
    check("t6_line1_w0", 64'(acc_data[(a0 + 4) % 64]), 64'h0001_0000);
    test_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
